// File: rtl/sram_mbist.sv
// Single-port synchronous SRAM with per-byte write enables and an integrated
// March C- self-test engine that takes exclusive ownership of the array while it runs.
module sram_mbist #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int MEM_BITW  = 10,
    localparam int NUM_BYTES = MEM_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 csn,
    input  logic                 we,
    input  logic [NUM_BYTES-1:0] be,
    input  logic [MEM_BITW-1:0]  addr,
    input  logic [MEM_WIDTH-1:0] din,
    output logic [MEM_WIDTH-1:0] dout,
    input  logic                 bist_start,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic                 bist_fail,
    output logic [MEM_BITW-1:0]  bist_fail_addr,
    output logic [2:0]           bist_fail_elem
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_BITW-1:0] LAST_ADDR = MEM_BITW'(MEM_DEPTH - 1);
    localparam logic [MEM_BITW:0]   DEPTH_EXT = (MEM_BITW + 1)'(MEM_DEPTH);
    localparam logic [MEM_WIDTH-1:0] ALL0 = {MEM_WIDTH{1'b0}};
    localparam logic [MEM_WIDTH-1:0] ALL1 = {MEM_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    state_t               state_q, state_d;
    logic [2:0]           elem_q, elem_d;
    logic                 phase_q, phase_d;
    logic [MEM_BITW-1:0]  baddr_q, baddr_d;

    logic                 cmp_vld_q;
    logic [MEM_WIDTH-1:0] cmp_exp_q;
    logic [MEM_BITW-1:0]  cmp_addr_q;
    logic [2:0]           cmp_elem_q;

    logic                 busy_q, done_q, fail_q;
    logic [MEM_BITW-1:0]  fail_addr_q;
    logic [2:0]           fail_elem_q;
    logic [MEM_WIDTH-1:0] dout_q;
    logic [MEM_WIDTH-1:0] rdata_q;
    logic [MEM_WIDTH-1:0] mem_rdata;

    logic                 idle_like_s, start_s, run_s, func_sel_s;
    logic                 bist_rd_s, bist_wr_s, single_op_s, step_done_s;
    logic                 up_s, at_end_s;
    logic [MEM_WIDTH-1:0] bist_exp_s, bist_wdata_s;
    logic [MEM_BITW-1:0]  arr_addr_s;
    logic [IDX_W-1:0]     arr_idx_s;
    logic [NUM_BYTES-1:0] arr_be_s;
    logic [MEM_WIDTH-1:0] arr_wdata_s;
    logic                 arr_ok_s, arr_we_s;

    assign mem_rdata = rdata_q;

    // Decode which array operation the current march element performs this cycle.
    always_comb begin
        bist_rd_s   = 1'b0;
        bist_wr_s   = 1'b0;
        single_op_s = 1'b0;
        case (elem_q)
            3'd0: begin
                bist_wr_s   = 1'b1;
                single_op_s = 1'b1;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
                bist_rd_s = ~phase_q;
                bist_wr_s = phase_q;
            end
            3'd5: begin
                bist_rd_s   = 1'b1;
                single_op_s = 1'b1;
            end
            default: begin
                bist_rd_s   = 1'b0;
                bist_wr_s   = 1'b0;
                single_op_s = 1'b1;
            end
        endcase
        bist_exp_s   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ALL1 : ALL0;
        bist_wdata_s = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ALL1 : ALL0;
        up_s         = (elem_q <= 3'd2);
        at_end_s     = up_s ? (baddr_q == LAST_ADDR) : (baddr_q == {MEM_BITW{1'b0}});
        step_done_s  = single_op_s | phase_q;
    end

    // Arbitrate the single array port between the BIST engine and the functional port.
    always_comb begin
        idle_like_s = (state_q == ST_IDLE) || (state_q == ST_DONE);
        start_s     = idle_like_s && bist_start;
        run_s       = (state_q == ST_RUN);
        func_sel_s  = idle_like_s && !bist_start && !csn;
        if (run_s) begin
            arr_addr_s  = baddr_q;
            arr_be_s    = {NUM_BYTES{1'b1}};
            arr_wdata_s = bist_wdata_s;
        end else begin
            arr_addr_s  = addr;
            arr_be_s    = be;
            arr_wdata_s = din;
        end
        arr_ok_s  = ({1'b0, arr_addr_s} < DEPTH_EXT);
        arr_idx_s = arr_addr_s[IDX_W-1:0];
        arr_we_s  = rst_n && arr_ok_s && ((run_s && bist_wr_s) || (func_sel_s && we));
    end

    // Sequencer next state: march element, read/write phase and address counter.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        phase_d = phase_q;
        baddr_d = baddr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    state_d = ST_RUN;
                    elem_d  = 3'd0;
                    phase_d = 1'b0;
                    baddr_d = {MEM_BITW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (step_done_s) begin
                    phase_d = 1'b0;
                    if (at_end_s) begin
                        if (elem_q == 3'd5) begin
                            state_d = ST_FLUSH;
                        end else begin
                            elem_d  = elem_q + 3'd1;
                            // Elements 3..5 run downward and start from the top word.
                            baddr_d = (elem_q >= 3'd2) ? LAST_ADDR : {MEM_BITW{1'b0}};
                        end
                    end else begin
                        baddr_d = up_s ? (baddr_q + MEM_BITW'(1)) : (baddr_q - MEM_BITW'(1));
                    end
                end else begin
                    phase_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Array storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (arr_we_s) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (arr_be_s[k]) begin
                    mem[arr_idx_s][8*k +: 8] <= arr_wdata_s[8*k +: 8];
                end
            end
        end
    end

    // Read registers: BIST read data for the compare stage and functional dout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= ALL0;
            dout_q  <= ALL0;
        end else begin
            if (run_s && bist_rd_s) begin
                rdata_q <= mem[arr_idx_s];
            end
            if (func_sel_s && !we) begin
                dout_q <= arr_ok_s ? mem[arr_idx_s] : ALL0;
            end
        end
    end

    // BIST controller: state, compare pipeline and sticky status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= 3'd0;
            phase_q     <= 1'b0;
            baddr_q     <= {MEM_BITW{1'b0}};
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= ALL0;
            cmp_addr_q  <= {MEM_BITW{1'b0}};
            cmp_elem_q  <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= {MEM_BITW{1'b0}};
            fail_elem_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            phase_q    <= phase_d;
            baddr_q    <= baddr_d;
            cmp_vld_q  <= run_s && bist_rd_s;
            cmp_exp_q  <= bist_exp_s;
            cmp_addr_q <= baddr_q;
            cmp_elem_q <= elem_q;
            if (start_s) begin
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
                fail_q      <= 1'b0;
                fail_addr_q <= {MEM_BITW{1'b0}};
                fail_elem_q <= 3'd0;
            end else begin
                if (state_q == ST_FLUSH) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                if (cmp_vld_q && (mem_rdata != cmp_exp_q)) begin
                    fail_q <= 1'b1;
                    if (!fail_q) begin
                        fail_addr_q <= cmp_addr_q;
                        fail_elem_q <= cmp_elem_q;
                    end
                end
            end
        end
    end

    assign dout           = dout_q;
    assign bist_busy      = busy_q;
    assign bist_done      = done_q;
    assign bist_fail      = fail_q;
    assign bist_fail_addr = fail_addr_q;
    assign bist_fail_elem = fail_elem_q;

endmodule

// File: tb/tb_sram_mbist.sv
// Bench for sram_mbist: table-driven functional vectors through a read scoreboard,
// plus BIST runs covering clean pass, injected fault, collisions and mid-run reset.
module tb_sram_mbist;

    localparam int D = 16;

    logic        clk;
    logic        rst_n;
    logic        csn;
    logic        we;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        bist_start;
    logic        bist_busy;
    logic        bist_done;
    logic        bist_fail;
    logic [4:0]  bist_fail_addr;
    logic [2:0]  bist_fail_elem;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic inject = 1'b0;

    typedef struct {
        logic        csn;
        logic        we;
        logic [3:0]  be;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[14];

    sram_mbist #(.MEM_WIDTH(32), .MEM_DEPTH(D), .MEM_BITW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csn            (csn),
        .we             (we),
        .be             (be),
        .addr           (addr),
        .din            (din),
        .dout           (dout),
        .bist_start     (bist_start),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_addr (bist_fail_addr),
        .bist_fail_elem (bist_fail_elem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fault injection: corrupt bit 0 of the compared read data for address 5.
    always @(negedge clk) begin
        if (inject && dut.cmp_vld_q && (dut.cmp_addr_q == 5'd5)) begin
            force dut.mem_rdata = 32'h0000_0001;
        end else begin
            release dut.mem_rdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        csn  = v.csn;
        we   = v.we;
        be   = v.be;
        addr = v.addr;
        din  = v.din;
        exp_q.push_back(v.exp_dout);
        @(posedge clk);
        #1;
        csn = 1'b1;
        we  = 1'b0;
        check(name, dout, exp_q.pop_front());
    endtask

    task automatic read_all_zero(input string tag);
        vec_t v;
        for (int a = 0; a < D; a++) begin
            v = '{1'b0, 1'b0, 4'h0, 5'(a), 32'h0, 32'h0};
            apply($sformatf("%s_rd%0d", tag, a), v);
        end
    endtask

    // Pulse bist_start (caller may pre-drive a colliding functional access) and
    // count busy cycles; optional stray start, functional write/read, and reset points.
    task automatic run_bist(input int stray_at, input int wr_at, input int rst_at,
                            output int busy_cnt);
        bist_start = 1'b1;
        @(posedge clk);
        #1;
        bist_start = 1'b0;
        csn = 1'b1;
        we  = 1'b0;
        check("busy_on_start", {31'b0, bist_busy}, 32'd1);
        check("done_cleared", {31'b0, bist_done}, 32'd0);
        check("fail_cleared", {31'b0, bist_fail}, 32'd0);
        busy_cnt = 0;
        while (bist_busy && busy_cnt < 400) begin
            busy_cnt++;
            bist_start = (busy_cnt == stray_at);
            csn  = !((busy_cnt == wr_at) || (busy_cnt == wr_at + 1));
            we   = (busy_cnt == wr_at);
            addr = (busy_cnt == wr_at) ? 5'd2 : 5'd3;
            din  = 32'hFFFF_FFFF;
            be   = 4'hF;
            rst_n = (busy_cnt != rst_at);
            @(posedge clk);
            #1;
            if (busy_cnt == rst_at) break;
        end
        bist_start = 1'b0;
        csn = 1'b1;
        we  = 1'b0;
    endtask

    initial begin
        int cnt;

        vecs[0]  = '{1'b0, 1'b1, 4'hF,    5'd3,  32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b0, 4'h0,    5'd3,  32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 4'b0101, 5'd3,  32'h1122_3344, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b0, 4'h0,    5'd3,  32'h0,         32'hDE22_BE44};
        vecs[4]  = '{1'b0, 1'b1, 4'hF,    5'd7,  32'hCAFE_F00D, 32'hDE22_BE44};
        vecs[5]  = '{1'b0, 1'b1, 4'b1010, 5'd7,  32'h0000_0000, 32'hDE22_BE44};
        vecs[6]  = '{1'b0, 1'b0, 4'h0,    5'd7,  32'h0,         32'h00FE_000D};
        vecs[7]  = '{1'b1, 1'b0, 4'h0,    5'd3,  32'h0,         32'h00FE_000D};
        vecs[8]  = '{1'b0, 1'b1, 4'hF,    5'd20, 32'hFFFF_FFFF, 32'h00FE_000D};
        vecs[9]  = '{1'b0, 1'b0, 4'h0,    5'd20, 32'h0,         32'h0000_0000};
        vecs[10] = '{1'b0, 1'b1, 4'hF,    5'd15, 32'h0F0F_0F0F, 32'h0000_0000};
        vecs[11] = '{1'b0, 1'b0, 4'h0,    5'd15, 32'h0,         32'h0F0F_0F0F};
        vecs[12] = '{1'b1, 1'b1, 4'hF,    5'd15, 32'h0,         32'h0F0F_0F0F};
        vecs[13] = '{1'b0, 1'b0, 4'h0,    5'd15, 32'h0,         32'h0F0F_0F0F};

        rst_n = 1'b0; csn = 1'b1; we = 1'b0; be = 4'h0; addr = 5'd0;
        din = 32'h0; bist_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 32'h0);
        check("rst_busy", {31'b0, bist_busy}, 32'd0);
        check("rst_done", {31'b0, bist_done}, 32'd0);
        check("rst_fail", {31'b0, bist_fail}, 32'd0);
        check("rst_fail_addr", {27'b0, bist_fail_addr}, 32'd0);
        check("rst_fail_elem", {29'b0, bist_fail_elem}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Clean run; start collides with a functional read of addr 3 (must be dropped).
        csn = 1'b0; we = 1'b0; addr = 5'd3;
        run_bist(30, 40, -1, cnt);
        check("clean_busy_cycles", 32'(cnt), 32'd161);
        check("clean_done", {31'b0, bist_done}, 32'd1);
        check("clean_fail", {31'b0, bist_fail}, 32'd0);
        check("clean_dout_held", dout, 32'h0F0F_0F0F);
        read_all_zero("clean");

        inject = 1'b1;
        run_bist(-1, -1, -1, cnt);
        inject = 1'b0;
        @(negedge clk);
        #1;
        check("fault_busy_cycles", 32'(cnt), 32'd161);
        check("fault_done", {31'b0, bist_done}, 32'd1);
        check("fault_fail", {31'b0, bist_fail}, 32'd1);
        check("fault_addr", {27'b0, bist_fail_addr}, 32'd5);
        check("fault_elem", {29'b0, bist_fail_elem}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("fault_sticky", {31'b0, bist_fail}, 32'd1);

        run_bist(-1, -1, 50, cnt);
        check("abort_cycle", 32'(cnt), 32'd50);
        check("abort_busy", {31'b0, bist_busy}, 32'd0);
        check("abort_done", {31'b0, bist_done}, 32'd0);
        check("abort_fail", {31'b0, bist_fail}, 32'd0);
        check("abort_fail_addr", {27'b0, bist_fail_addr}, 32'd0);
        check("abort_fail_elem", {29'b0, bist_fail_elem}, 32'd0);
        check("abort_dout", dout, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle_busy", {31'b0, bist_busy}, 32'd0);

        run_bist(-1, -1, -1, cnt);
        check("rerun_busy_cycles", 32'(cnt), 32'd161);
        check("rerun_done", {31'b0, bist_done}, 32'd1);
        check("rerun_fail", {31'b0, bist_fail}, 32'd0);
        read_all_zero("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
